data_mem_responder: RTL

//  Memory-side responder for core load/store requests. It replaces the zero-latency data

---
 rtl/data_mem_responder_pkg.sv | 28 ++
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder_lane_align.sv | 47 ++++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared funct3 codes, access sizes and FSM encoding
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Access size is funct3[1:0] for every legal load and store encoding.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle between core and responder
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// rtl/data_mem_responder_lane_align.sv - byte-lane steering for stores and load extension
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        zero_ext;

    always_comb begin
        sel_byte    = raw_word[{addr_lo, 3'b000} +: 8];
        sel_half    = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        zero_ext    = funct3[2];
        byte_en     = 4'b0000;
        wdata_lanes = wdata;
        rdata_ext   = raw_word;
        misalign    = 1'b0;
        case (funct3[1:0])
            SZ_B: begin
                byte_en     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = zero_ext ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            end
            SZ_H: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = zero_ext ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
                misalign    = addr_lo[0];
            end
            SZ_W: begin
                byte_en  = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - handshaked load/store target with wait states over a word RAM
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ready_en_q, ready_en_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          commit;
    logic          access_err;
    logic          ram_we;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lanes;
    logic [31:0]   rdata_ext;
    logic          misalign;

    mem_lane_align u_lane_align (
        .funct3      (funct3_q),
        .addr_lo     (offset[1:0]),
        .wdata       (wdata_q),
        .raw_word    (ram[word_idx]),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign)
    );

    // Commit happens on the edge that leaves WAIT, always from the latched request.
    always_comb begin
        offset     = addr_q - ADDR_BASE;
        word_idx   = offset[AW+1:2];
        commit     = (state_q == ST_WAIT) && (cnt_q == 4'd0);
        access_err = misalign || !f3_legal(we_q, funct3_q) || (offset[31:AW+2] != '0);
        ram_we     = commit && we_q && !access_err && reset;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            ready_en_q  <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_en_q  <= ready_en_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
                end
            end
        end
    end

    // An accepted request spends WAIT_CYCLES+1 cycles in WAIT: one to register it,
    // then the programmed wait states, so the response lands 1+WAIT_CYCLES edges later.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_en_d  = 1'b1;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && ready_en_q) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = 4'(WAIT_CYCLES);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESP;
                    rsp_err_d   = access_err;
                    rsp_rdata_d = (access_err || we_q) ? 32'h0 : rdata_ext;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == ST_IDLE) && ready_en_q;
        bus.rsp_valid = (state_q == ST_RESP);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
    end

endmodule
